cp_preprocessor: RTL and testbench

// - Decompression-side CCSDS-121 post-processor: inverse mapper plus unit-delay predictor.
// - Reads N-bit mapped prediction residuals (delta) from an internal ROM, as produced by the

---
 rtl/cp_preprocessor.sv | 130 +++++++++++++
 tb/tb_cp_preprocessor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cp_preprocessor.sv
// CCSDS-121 decompression post-processor: inverse mapper plus unit-delay predictor.
// Pulls mapped residuals from resid_rom, rebuilds samples and stores them in out_ram.
module cp_preprocessor #(
    parameter int N          = 8,
    parameter int J          = 16,
    parameter int NUM_BLOCKS = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    output logic datavalid,
    output logic cdsdatavalid,
    output logic wren
);

    localparam int S  = J * NUM_BLOCKS;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int PW = (J > 1) ? $clog2(J) : 1;
    localparam logic [N-1:0] XMAX = '1;

    typedef enum logic [2:0] {IDLE, FETCH, MAP, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [N-1:0]  xp_q, xp_d;
    logic [N-1:0]  x_out_q, x_out_d;
    logic [N-1:0]  delta_q;
    logic [N-1:0]  x_calc;
    logic          lastSample, lastInBlock;

    logic [N-1:0]  resid_rom [S];
    logic [N-1:0]  out_ram   [S];

    initial begin
        for (int i = 0; i < S; i++) resid_rom[i] = '0;
    end

    assign lastSample  = (idx_q == IW'(S - 1));
    assign lastInBlock = (pos_q == PW'(J - 1));

    // Synchronous ROM read: address presented in FETCH, data usable in MAP.
    always_ff @(posedge clk) begin
        delta_q <= resid_rom[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == WRITE) out_ram[idx_q] <= x_out_q;
    end

    // Inverse mapping in N+2-bit signed arithmetic; pos_q tracks idx % J.
    always_comb begin
        logic signed [N+1:0] xpS, dS, thS, dD, sum, upS;
        xpS = {2'b00, xp_q};
        dS  = {2'b00, delta_q};
        upS = {2'b00, XMAX} - xpS;
        thS = (xpS < upS) ? xpS : upS;
        if (dS <= (thS <<< 1)) begin
            if (delta_q[0]) dD = -((dS + (N+2)'(1)) >>> 1);
            else            dD = dS >>> 1;
        end else if (xpS <= upS) begin
            dD = dS - thS;
        end else begin
            dD = thS - dS;
        end
        sum    = xpS + dD;
        x_calc = (pos_q == '0) ? delta_q : sum[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            xp_q    <= '0;
            x_out_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            xp_q    <= xp_d;
            x_out_q <= x_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pos_d        = pos_q;
        xp_d         = xp_q;
        x_out_d      = x_out_q;
        wren         = 1'b0;
        datavalid    = 1'b0;
        cdsdatavalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    pos_d   = '0;
                end
            end
            FETCH: state_d = MAP;
            MAP: begin
                x_out_d = x_calc;
                state_d = WRITE;
            end
            WRITE: begin
                wren         = 1'b1;
                datavalid    = 1'b1;
                cdsdatavalid = lastInBlock;
                xp_d         = x_out_q;
                if (lastSample) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    pos_d   = lastInBlock ? '0 : pos_q + PW'(1);
                    state_d = FETCH;
                end
            end
            // Wait for go to drop so a held-high go produces a single run.
            DONE: begin
                if (!go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cp_preprocessor.sv
// Self-checking bench for cp_preprocessor: directed and random residual blocks
// compared against an integer model of the inverse mapper and predictor.
module tb_cp_preprocessor;

    localparam int N  = 8;
    localparam int J  = 4;
    localparam int NB = 4;
    localparam int S  = J * NB;
    localparam int XM = 255;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic go = 1'b0;
    logic datavalid, cdsdatavalid, wren;

    int nChecks = 0;
    int nPass   = 0;
    int romImg [S];
    int expX   [S];

    cp_preprocessor #(.N(N), .J(J), .NUM_BLOCKS(NB), .INIT_FILE("")) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .datavalid(datavalid),
        .cdsdatavalid(cdsdatavalid),
        .wren(wren)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Reference model: plain integer evaluation of the mapping rules.
    function automatic void buildModel();
        int xp, d, theta, dd, x;
        xp = 0;
        for (int i = 0; i < S; i++) begin
            d = romImg[i];
            if (i % J == 0) begin
                x = d;
            end else begin
                theta = (xp < XM - xp) ? xp : XM - xp;
                if (d <= 2 * theta) dd = (d % 2 == 0) ? d / 2 : -((d + 1) / 2);
                else                dd = (xp <= XM - xp) ? d - theta : theta - d;
                x = xp + dd;
            end
            expX[i] = x;
            xp = x;
        end
    endfunction

    task automatic loadRom();
        for (int i = 0; i < S; i++) dut.resid_rom[i] = 8'(romImg[i]);
    endtask

    task automatic randomRom();
        for (int i = 0; i < S; i++) begin
            case ($urandom_range(0, 3))
                0:       romImg[i] = 0;
                1:       romImg[i] = 255;
                default: romImg[i] = $urandom_range(0, 255);
            endcase
        end
    endtask

    task automatic applyStimulus(input string name, input bit dropGo);
        logic expW, expC;
        buildModel();
        @(negedge clk);
        loadRom();
        go = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 3 * S + 4; c++) begin
            @(negedge clk);
            if (dropGo && c == 7) go = 1'b0;
            expW = (c % 3 == 2) && (c < 3 * S);
            expC = expW && (((c / 3) % J) == J - 1);
            checkOutput($sformatf("%s wren c%0d", name, c), wren, expW);
            checkOutput($sformatf("%s datavalid c%0d", name, c), datavalid, expW);
            checkOutput($sformatf("%s cdsdatavalid c%0d", name, c), cdsdatavalid, expC);
            if (expW) checkOutput($sformatf("%s x_out s%0d", name, c / 3), dut.x_out_q, expX[c / 3]);
        end
        for (int i = 0; i < S; i++)
            checkOutput($sformatf("%s out_ram[%0d]", name, i), dut.out_ram[i], expX[i]);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");

        reset = 1'b0;
        go    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("reset wren", wren, 1'b0);
            checkOutput("reset datavalid", datavalid, 1'b0);
            checkOutput("reset cdsdatavalid", cdsdatavalid, 1'b0);
            checkOutput("reset x_out", dut.x_out_q, 0);
            checkOutput("reset idx", dut.idx_q, 0);
        end
        go = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("idle wren", wren, 1'b0);
        end

        romImg = '{100, 0, 1, 2, 100, 250, 7, 3, 200, 120, 9, 4, 0, 5, 6, 1};
        applyStimulus("run1", 1'b0);
        checkOutput("basic ram0", dut.out_ram[0], 100);
        checkOutput("basic ram1", dut.out_ram[1], 100);
        checkOutput("basic ram2", dut.out_ram[2], 99);
        checkOutput("basic ram3", dut.out_ram[3], 100);
        checkOutput("oor low", dut.out_ram[5], 250);
        checkOutput("oor high", dut.out_ram[9], 135);
        checkOutput("edge xp0", dut.out_ram[13], 5);

        applyStimulus("run1again", 1'b0);

        romImg = '{255, 5, 2, 3, 255, 0, 1, 1, 0, 0, 0, 0, 255, 255, 255, 0};
        applyStimulus("edges", 1'b0);
        checkOutput("edge xpmax d5", dut.out_ram[1], 250);
        checkOutput("edge xpmax d0", dut.out_ram[5], 255);

        for (int r = 0; r < 3; r++) begin
            randomRom();
            applyStimulus($sformatf("rand%0d", r), (r == 1));
        end

        randomRom();
        @(negedge clk);
        loadRom();
        go = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        go    = 1'b0;
        @(negedge clk);
        checkOutput("abort wren", wren, 1'b0);
        checkOutput("abort datavalid", datavalid, 1'b0);
        checkOutput("abort cdsdatavalid", cdsdatavalid, 1'b0);
        checkOutput("abort idx", dut.idx_q, 0);
        checkOutput("abort x_out", dut.x_out_q, 0);
        checkOutput("abort xp", dut.xp_q, 0);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("post-abort wren", wren, 1'b0);
        end

        randomRom();
        applyStimulus("recover", 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
